// File: rtl/frame_repeat_buffer_if.sv
// Frame-level handshake bundle for frame_repeat_buffer.
// FRAME_REPEAT_BUFFER_CNT_EN adds the frame_cnt output.
interface frame_repeat_buffer_if #(
  parameter int IN_LENGTH  = 16,
  parameter int OUT_LENGTH = 32
);
  logic [0:IN_LENGTH-1][31:0]  idata;
  logic                        ien_data;
  logic                        ien;
  logic                        fct;
  logic [0:OUT_LENGTH-1][31:0] odata;
  logic                        oen;
  logic                        full;
`ifdef FRAME_REPEAT_BUFFER_CNT_EN
  logic [15:0]                 frame_cnt;

  modport master (
    output idata, ien_data, ien, fct,
    input  odata, oen, full, frame_cnt
  );
  modport slave (
    input  idata, ien_data, ien, fct,
    output odata, oen, full, frame_cnt
  );
`else
  modport master (
    output idata, ien_data, ien, fct,
    input  odata, oen, full
  );
  modport slave (
    input  idata, ien_data, ien, fct,
    output odata, oen, full
  );
`endif
endinterface

// File: rtl/frame_repeat_buffer.sv
// Input frame FIFO -> cyclic repeat expansion -> output frame FIFO.
// Optional macro FRAME_REPEAT_BUFFER_CNT_EN adds a popped-frame counter.
module frame_repeat_buffer #(
  parameter int IN_LENGTH         = 16,
  parameter int OUT_LENGTH        = 32,
  parameter int NB_INPUT_PROCESS  = 2,
  parameter int NB_OUTPUT_PROCESS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  frame_repeat_buffer_if.slave bus
);

  localparam int IPW =
    (NB_INPUT_PROCESS > 1) ? $clog2(NB_INPUT_PROCESS) : 1;
  localparam int OPW =
    (NB_OUTPUT_PROCESS > 1) ? $clog2(NB_OUTPUT_PROCESS) : 1;
  localparam int ICW = $clog2(NB_INPUT_PROCESS + 1);
  localparam int OCW = $clog2(NB_OUTPUT_PROCESS + 1);

  typedef logic [0:IN_LENGTH-1][31:0]  in_frame_t;
  typedef logic [0:OUT_LENGTH-1][31:0] out_frame_t;

  in_frame_t  in_mem  [NB_INPUT_PROCESS];
  out_frame_t out_mem [NB_OUTPUT_PROCESS];

  logic [IPW-1:0] in_wr;
  logic [IPW-1:0] in_rd;
  logic [ICW-1:0] in_cnt;
  logic [OPW-1:0] out_wr;
  logic [OPW-1:0] out_rd;
  logic [OCW-1:0] out_cnt;
  logic           s_q;

  logic       strobe;
  logic       accept;
  logic       xfer;
  logic       pop;
  logic       in_full;
  logic       out_full;
  out_frame_t xfer_frame;

  function automatic logic [IPW-1:0] in_nxt(input logic [IPW-1:0] p);
    return (p == IPW'(NB_INPUT_PROCESS - 1)) ? '0 : p + IPW'(1);
  endfunction

  function automatic logic [OPW-1:0] out_nxt(input logic [OPW-1:0] p);
    return (p == OPW'(NB_OUTPUT_PROCESS - 1)) ? '0 : p + OPW'(1);
  endfunction

  assign strobe   = bus.ien & bus.ien_data;
  assign in_full  = (in_cnt == ICW'(NB_INPUT_PROCESS));
  assign out_full = (out_cnt == OCW'(NB_OUTPUT_PROCESS));
  assign pop      = bus.oen & bus.fct;
  assign accept   = strobe & ~s_q & ~in_full;
  // a slot freed by this cycle's pop may be refilled immediately
  assign xfer     = (in_cnt != '0) & (~out_full | pop);

  always_comb begin
    xfer_frame = '0;
    for (int j = 0; j < OUT_LENGTH; j++) begin
      xfer_frame[j] = in_mem[in_rd][j % IN_LENGTH];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) in_mem[in_wr] <= bus.idata;
    if (xfer) out_mem[out_wr] <= xfer_frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b1;
      in_wr   <= '0;
      in_rd   <= '0;
      in_cnt  <= '0;
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      s_q <= strobe;
      if (accept) in_wr <= in_nxt(in_wr);
      if (xfer) begin
        in_rd  <= in_nxt(in_rd);
        out_wr <= out_nxt(out_wr);
      end
      if (pop) out_rd <= out_nxt(out_rd);
      in_cnt  <= in_cnt + ICW'(accept) - ICW'(xfer);
      out_cnt <= out_cnt + OCW'(xfer) - OCW'(pop);
    end
  end

  assign bus.full  = in_full;
  assign bus.oen   = (out_cnt != '0);
  assign bus.odata = bus.oen ? out_mem[out_rd] : '0;

`ifdef FRAME_REPEAT_BUFFER_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (pop) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_repeat_buffer.sv
// Scoreboard bench for frame_repeat_buffer: queue-level model,
// directed test-plan scenarios plus randomized traffic.
module tb_frame_repeat_buffer;

  localparam int IL = 16;
  localparam int OL = 32;
  localparam int NI = 2;
  localparam int NO = 4;

  typedef logic [0:IL-1][31:0] fin_t;
  typedef logic [0:OL-1][31:0] fout_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  frame_repeat_buffer_if #(.IN_LENGTH(IL), .OUT_LENGTH(OL)) bus ();

  frame_repeat_buffer #(
    .IN_LENGTH(IL),
    .OUT_LENGTH(OL),
    .NB_INPUT_PROCESS(NI),
    .NB_OUTPUT_PROCESS(NO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  fout_t       exp_q[$];
  fout_t       last_out = '0;
  int          m_in  = 0;
  int          m_out = 0;
  logic        m_s   = 1'b1;
  logic [15:0] m_cnt = '0;

  function automatic fout_t expand(input fin_t f);
    fout_t o;
    for (int j = 0; j < OL; j++) o[j] = f[j % IL];
    return o;
  endfunction

  function automatic fin_t rnd_frame();
    fin_t f;
    for (int i = 0; i < IL; i++) f[i] = $urandom;
    return f;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input fout_t act,
                             input fout_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got w0=%0h w%0d=%0h expected w0=%0h w%0d=%0h",
               nm, act[0], OL-1, act[OL-1], exp[0], OL-1, exp[OL-1]);
    end
  endtask

  // queue-level reference: counts of frames waiting in each stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_in  = 0;
      m_out = 0;
      m_s   = 1'b1;
      m_cnt = '0;
    end else begin
      logic st, edg, pp, xf, ac;
      st  = bus.ien & bus.ien_data;
      edg = st & ~m_s;
      m_s = st;
      pp  = (m_out > 0) && bus.fct;
      xf  = (m_in > 0) && ((m_out < NO) || pp);
      ac  = edg && (m_in < NI);
      if (ac) exp_q.push_back(expand(bus.idata));
      m_in  = m_in + int'(ac) - int'(xf);
      m_out = m_out + int'(xf) - int'(pp);
      if (pp) m_cnt = m_cnt + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("oen", 32'(bus.oen), 32'(m_out != 0));
      check("full", 32'(bus.full), 32'(m_in == NI));
`ifdef FRAME_REPEAT_BUFFER_CNT_EN
      check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
`endif
      if (bus.oen && bus.fct) begin
        n_pop++;
        last_out = bus.odata;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got w0=%0h expected no frame",
                   bus.odata[0]);
        end else begin
          check_frame("odata", bus.odata, exp_q.pop_front());
        end
      end else if (!bus.oen) begin
        check_frame("odata_idle", bus.odata, '0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input fin_t f, input int hold);
    bus.idata    = f;
    bus.ien      = 1'b1;
    bus.ien_data = 1'b1;
    cyc(hold);
    bus.ien      = 1'b0;
    bus.ien_data = 1'b0;
    cyc(1);
  endtask

  fin_t fa, fb, fn, fr;
  fin_t fill[7];
  int   p0;
  int   waited;

  initial begin
    bus.idata    = '0;
    bus.ien      = 1'b0;
    bus.ien_data = 1'b0;
    bus.fct      = 1'b1;
    for (int i = 0; i < IL; i++) begin
      fa[i] = 32'h1 << i;
      fb[i] = 32'h8000_0000 >> i;
    end
    #1;
    check("rst_oen", 32'(bus.oen), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check_frame("rst_odata", bus.odata, '0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // single frame, strobe held 2 cycles
    p0 = n_pop;
    send(fa, 2);
    cyc(5);
    check("single_count", 32'(n_pop - p0), 32'd1);
    check("single_w0", last_out[0], 32'h1);
    check("single_w15", last_out[15], 32'h8000);
    check("single_w16", last_out[16], 32'h1);
    check("single_w31", last_out[31], 32'h8000);

    // back-to-back A then B
    p0 = n_pop;
    send(fa, 1);
    cyc(3);
    send(fb, 1);
    cyc(5);
    check("ab_count", 32'(n_pop - p0), 32'd2);
    check("b_w0", last_out[0], 32'h8000_0000);
    check("b_w16", last_out[16], 32'h8000_0000);

    // back-pressure fill, 7th strobe dropped
    bus.fct = 1'b0;
    for (int k = 0; k < 7; k++) begin
      fill[k] = rnd_frame();
      send(fill[k], 1);
    end
    cyc(2);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_oen", 32'(bus.oen), 32'd1);
    check("fill_head", bus.odata[0], fill[0][0]);

    // drain
    p0 = n_pop;
    bus.fct = 1'b1;
    cyc(12);
    check("drain_count", 32'(n_pop - p0), 32'd6);
    check("drain_oen", 32'(bus.oen), 32'd0);
    check("drain_last", last_out[0], fill[5][0]);

    // wait for not-full, then a new frame goes last
    bus.fct = 1'b0;
    for (int k = 0; k < 6; k++) send(rnd_frame(), 1);
    cyc(1);
    check("wnf_full", 32'(bus.full), 32'd1);
    bus.fct = 1'b1;
    waited = 0;
    while (bus.full && waited < 20) begin
      cyc(1);
      waited++;
    end
    check("wnf_timeout", 32'(bus.full), 32'd0);
    fn = rnd_frame();
    send(fn, 1);
    cyc(12);
    check_frame("wnf_last", last_out, expand(fn));
    check("wnf_empty", 32'(bus.oen), 32'd0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.idata    = rnd_frame();
      bus.ien      = 1'($urandom_range(0, 1));
      bus.ien_data = 1'($urandom_range(0, 3) != 0);
      bus.fct      = 1'($urandom_range(0, 2) != 0);
      cyc(1);
    end
    bus.ien      = 1'b0;
    bus.ien_data = 1'b0;
    bus.fct      = 1'b1;
    cyc(12);
    check("rand_empty", 32'(bus.oen), 32'd0);

    // async reset mid-operation
    bus.fct = 1'b0;
    for (int k = 0; k < 4; k++) send(rnd_frame(), 1);
    bus.ien      = 1'b1;
    bus.ien_data = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_oen", 32'(bus.oen), 32'd0);
    check("arst_full", 32'(bus.full), 32'd0);
    check_frame("arst_odata", bus.odata, '0);
`ifdef FRAME_REPEAT_BUFFER_CNT_EN
    check("arst_cnt", 32'(bus.frame_cnt), 32'd0);
`endif
    bus.fct = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    p0 = n_pop;
    cyc(4);
    check("held_strobe_pops", 32'(n_pop - p0), 32'd0);
    check("held_strobe_oen", 32'(bus.oen), 32'd0);
    bus.ien      = 1'b0;
    bus.ien_data = 1'b0;
    cyc(1);
    fr = rnd_frame();
    send(fr, 1);
    cyc(5);
    check("fresh_count", 32'(n_pop - p0), 32'd1);
    check_frame("fresh_frame", last_out, expand(fr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
